// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: debug controller state encoding and the default
// NOP word also used by decode.
package pipe_pkg;

    typedef enum logic [1:0] {
        DBG_RUN  = 2'b00,
        DBG_HALT = 2'b01,
        DBG_STEP = 2'b10
    } dbg_state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Inter-stage bus: upstream word, hazard controls and the registered stage outputs.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 8
);

    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic              out_valid;
    logic              flush_pending;

    modport master (
        output stall, flush, in_data, in_pc, in_valid,
        input  out_data, out_pc, out_valid, flush_pending
    );

    modport slave (
        input  stall, flush, in_data, in_pc, in_valid,
        output out_data, out_pc, out_valid, flush_pending
    );

endinterface

// File: rtl/dbg_step_ctrl.sv
// Debug run/halt/step-N controller. gate reflects the current (pre-transition)
// state; step_done pulses on the advance that consumes the last step.
module dbg_step_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned STEP_W    = 8,
    parameter bit          RESET_RUN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt_req,
    input  logic              run_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              stall,
    output dbg_state_t        state,
    output logic [STEP_W-1:0] steps_left,
    output logic              gate,
    output logic              step_done
);

    localparam dbg_state_t RESET_STATE = RESET_RUN ? DBG_RUN : DBG_HALT;

    dbg_state_t        state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              advance;

    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        step_done = 1'b0;
        gate      = (state_q == DBG_RUN) || (state_q == DBG_STEP);
        advance   = gate && !stall;

        unique case (state_q)
            DBG_RUN: begin
                if (halt_req) state_d = DBG_HALT;
            end
            DBG_HALT: begin
                // halt outranks run, run outranks step
                if (!halt_req) begin
                    if (run_req) begin
                        state_d = DBG_RUN;
                    end else if (step_req && (step_count != '0)) begin
                        state_d = DBG_STEP;
                        steps_d = step_count;
                    end
                end
            end
            DBG_STEP: begin
                if (halt_req) begin
                    state_d = DBG_HALT;
                    steps_d = '0;
                end else if (run_req) begin
                    state_d = DBG_RUN;
                    steps_d = '0;
                end else if (advance) begin
                    steps_d = steps_q - STEP_W'(1);
                    if (steps_q == STEP_W'(1)) begin
                        state_d   = DBG_HALT;
                        step_done = 1'b1;
                    end
                end
            end
            default: begin
                state_d = DBG_HALT;
                steps_d = '0;
            end
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
        end
    end

    assign state      = state_q;
    assign steps_left = steps_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush / remembered flush, debug
// run-halt-step gating and saturating stall/bubble counters. Updates on falling edge.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       PC_W      = 8,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_DEFAULT),
    parameter int unsigned       STEP_W    = 8,
    parameter int unsigned       CNT_W     = 16,
    parameter bit                RESET_RUN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              debug_reset,
    pipe_stage_reg_if.slave   bus,
    input  logic              dbg_halt_req,
    input  logic              dbg_run_req,
    input  logic              dbg_step_req,
    input  logic [STEP_W-1:0] dbg_step_count,
    output logic [1:0]        dbg_state,
    output logic [STEP_W-1:0] dbg_steps_left,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    dbg_state_t state;
    logic       gate;
    logic       advance;
    logic       step_done;

    // A debug_reset cycle must not consume a pending step.
    dbg_step_ctrl #(
        .STEP_W    (STEP_W),
        .RESET_RUN (RESET_RUN)
    ) u_dbg_step_ctrl (
        .clock      (clock),
        .reset      (reset),
        .halt_req   (dbg_halt_req),
        .run_req    (dbg_run_req),
        .step_req   (dbg_step_req),
        .step_count (dbg_step_count),
        .stall      (bus.stall | debug_reset),
        .state      (state),
        .steps_left (dbg_steps_left),
        .gate       (gate),
        .step_done  (step_done)
    );

    assign advance = gate && !bus.stall;

    always_comb begin
        data_d       = data_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        pending_d    = pending_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (debug_reset) begin
            data_d       = NOP_VALUE;
            pc_d         = '0;
            valid_d      = 1'b0;
            pending_d    = 1'b0;
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (advance) begin
                pc_d      = bus.in_pc;
                pending_d = 1'b0;
                if (bus.flush || pending_q) begin
                    data_d  = NOP_VALUE;
                    valid_d = 1'b0;
                    if (!(&bubble_cnt_q)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
                end else begin
                    data_d  = bus.in_data;
                    valid_d = bus.in_valid;
                end
            end else if (bus.flush) begin
                pending_d = 1'b1;
            end

            // Stalls while halted are not counted.
            if (gate && bus.stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            data_q       <= NOP_VALUE;
            pc_q         <= '0;
            valid_q      <= 1'b0;
            pending_q    <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            data_q       <= data_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            pending_q    <= pending_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.out_data      = data_q;
    assign bus.out_pc        = pc_q;
    assign bus.out_valid     = valid_q;
    assign bus.flush_pending = pending_q;
    assign dbg_state         = state;
    assign stall_cnt         = stall_cnt_q;
    assign bubble_cnt        = bubble_cnt_q;

    // The last step always lands the controller in HALT.
    a_step_done_halts: assert property (
        @(negedge clock) disable iff (reset) step_done |=> (dbg_state == DBG_HALT)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: hazard handling, debug stepping, debug_reset
// and counter saturation with a 4-bit counter build.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clock;
    logic reset;
    logic debug_reset;
    logic dbg_halt_req;
    logic dbg_run_req;
    logic dbg_step_req;
    logic [STEP_W-1:0] dbg_step_count;
    logic [1:0]        dbg_state;
    logic [STEP_W-1:0] dbg_steps_left;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks;
    int failures;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    pipe_stage_reg #(
        .DATA_W    (DATA_W),
        .PC_W      (PC_W),
        .NOP_VALUE (NOP),
        .STEP_W    (STEP_W),
        .CNT_W     (CNT_W),
        .RESET_RUN (1'b1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .debug_reset    (debug_reset),
        .bus            (bus),
        .dbg_halt_req   (dbg_halt_req),
        .dbg_run_req    (dbg_run_req),
        .dbg_step_req   (dbg_step_req),
        .dbg_step_count (dbg_step_count),
        .dbg_state      (dbg_state),
        .dbg_steps_left (dbg_steps_left),
        .stall_cnt      (stall_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one falling edge and settle just after it.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic set_in(input logic [31:0] d, input logic [7:0] pc);
        bus.in_data = d;
        bus.in_pc   = pc;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset          = 1'b1;
        debug_reset    = 1'b0;
        dbg_halt_req   = 1'b0;
        dbg_run_req    = 1'b0;
        dbg_step_req   = 1'b0;
        dbg_step_count = '0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b1;
        set_in(32'h1234_5678, 8'h04);
        #12;
        check_eq("rst_data", bus.out_data, NOP);
        check_eq("rst_pc", 32'(bus.out_pc), 32'h0);
        check_eq("rst_valid", 32'(bus.out_valid), 32'h0);
        check_eq("rst_pending", 32'(bus.flush_pending), 32'h0);
        check_eq("rst_state", 32'(dbg_state), 32'h0);
        check_eq("rst_steps", 32'(dbg_steps_left), 32'h0);
        check_eq("rst_cnts", {24'h0, stall_cnt, bubble_cnt}, 32'h0);
        reset = 1'b0;

        // Plain capture
        tick();
        check_eq("cap_data", bus.out_data, 32'h1234_5678);
        check_eq("cap_pc", 32'(bus.out_pc), 32'h04);
        check_eq("cap_valid", 32'(bus.out_valid), 32'h1);
        check_eq("cap_state", 32'(dbg_state), 32'h0);

        // Stall three cycles, flush in the second, then advance into a bubble
        bus.stall = 1'b1;
        set_in(32'h5A5A_5A5A, 8'h06);
        tick();
        check_eq("stall1_data", bus.out_data, 32'h1234_5678);
        check_eq("stall1_pend", 32'(bus.flush_pending), 32'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_eq("stall2_pend", 32'(bus.flush_pending), 32'h1);
        check_eq("stall2_pc", 32'(bus.out_pc), 32'h04);
        tick();
        check_eq("stall3_data", bus.out_data, 32'h1234_5678);
        bus.stall = 1'b0;
        set_in(32'hAAAA_0000, 8'h08);
        tick();
        check_eq("bub_data", bus.out_data, NOP);
        check_eq("bub_valid", 32'(bus.out_valid), 32'h0);
        check_eq("bub_pc", 32'(bus.out_pc), 32'h08);
        check_eq("bub_pend", 32'(bus.flush_pending), 32'h0);
        check_eq("bub_stallcnt", 32'(stall_cnt), 32'd3);
        check_eq("bub_bubblecnt", 32'(bubble_cnt), 32'd1);

        // Four direct flushes, then a normal capture
        bus.flush = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.flush = 1'b0;
        check_eq("flush4_bubblecnt", 32'(bubble_cnt), 32'd5);
        set_in(32'h5555_1111, 8'h0C);
        tick();
        check_eq("recap_data", bus.out_data, 32'h5555_1111);
        check_eq("recap_valid", 32'(bus.out_valid), 32'h1);

        // Halt: the sampling edge still captures, then outputs freeze
        dbg_halt_req = 1'b1;
        set_in(32'h2222_3333, 8'h10);
        tick();
        dbg_halt_req = 1'b0;
        check_eq("halt_edge_data", bus.out_data, 32'h2222_3333);
        check_eq("halt_state", 32'(dbg_state), 32'h1);
        for (int i = 0; i < 5; i++) begin
            set_in(32'h0BAD_0000 + 32'(i), 8'h20 + 8'(i));
            bus.stall = (i % 2) == 1;
            tick();
            check_eq("halt_frozen", bus.out_data, 32'h2222_3333);
        end
        bus.stall = 1'b0;
        check_eq("halt_pc", 32'(bus.out_pc), 32'h10);
        check_eq("halt_stallcnt", 32'(stall_cnt), 32'd3);
        check_eq("halt_state2", 32'(dbg_state), 32'h1);

        // Step 3 with one stalled cycle
        dbg_step_req   = 1'b1;
        dbg_step_count = 8'd3;
        set_in(32'h3000_0000, 8'h30);
        tick();
        dbg_step_req = 1'b0;
        check_eq("step_req_state", 32'(dbg_state), 32'h2);
        check_eq("step_req_left", 32'(dbg_steps_left), 32'd3);
        check_eq("step_req_data", bus.out_data, 32'h2222_3333);
        set_in(32'h3000_0001, 8'h31);
        tick();
        check_eq("step1_data", bus.out_data, 32'h3000_0001);
        check_eq("step1_left", 32'(dbg_steps_left), 32'd2);
        bus.stall = 1'b1;
        set_in(32'h3000_0002, 8'h32);
        tick();
        bus.stall = 1'b0;
        check_eq("step2_data", bus.out_data, 32'h3000_0001);
        check_eq("step2_left", 32'(dbg_steps_left), 32'd2);
        check_eq("step2_stallcnt", 32'(stall_cnt), 32'd4);
        set_in(32'h3000_0003, 8'h33);
        tick();
        check_eq("step3_data", bus.out_data, 32'h3000_0003);
        check_eq("step3_left", 32'(dbg_steps_left), 32'd1);
        set_in(32'h3000_0004, 8'h34);
        tick();
        check_eq("step4_data", bus.out_data, 32'h3000_0004);
        check_eq("step4_left", 32'(dbg_steps_left), 32'd0);
        check_eq("step4_state", 32'(dbg_state), 32'h1);
        set_in(32'h3000_0005, 8'h35);
        tick();
        check_eq("step_after_data", bus.out_data, 32'h3000_0004);

        // Step with count 0 is ignored
        dbg_step_req   = 1'b1;
        dbg_step_count = 8'd0;
        tick();
        dbg_step_req = 1'b0;
        check_eq("step0_state", 32'(dbg_state), 32'h1);
        check_eq("step0_left", 32'(dbg_steps_left), 32'd0);

        // Step 5 interrupted by run
        dbg_step_req   = 1'b1;
        dbg_step_count = 8'd5;
        set_in(32'h4000_0001, 8'h41);
        tick();
        dbg_step_req = 1'b0;
        check_eq("step5_left", 32'(dbg_steps_left), 32'd5);
        dbg_run_req = 1'b1;
        set_in(32'h4000_0002, 8'h42);
        tick();
        dbg_run_req = 1'b0;
        check_eq("step_run_state", 32'(dbg_state), 32'h0);
        check_eq("step_run_left", 32'(dbg_steps_left), 32'd0);
        check_eq("step_run_data", bus.out_data, 32'h4000_0002);

        // Halt and run together in RUN: halt wins
        dbg_halt_req = 1'b1;
        dbg_run_req  = 1'b1;
        set_in(32'h4000_0003, 8'h43);
        tick();
        dbg_halt_req = 1'b0;
        dbg_run_req  = 1'b0;
        check_eq("halt_run_state", 32'(dbg_state), 32'h1);
        check_eq("halt_run_data", bus.out_data, 32'h4000_0003);
        check_eq("pre_dr_valid", 32'(bus.out_valid), 32'h1);
        check_eq("pre_dr_bubblecnt", 32'(bubble_cnt), 32'd5);

        // debug_reset while halted
        debug_reset = 1'b1;
        tick();
        debug_reset = 1'b0;
        check_eq("dr_data", bus.out_data, NOP);
        check_eq("dr_pc", 32'(bus.out_pc), 32'h0);
        check_eq("dr_valid", 32'(bus.out_valid), 32'h0);
        check_eq("dr_cnts", {24'h0, stall_cnt, bubble_cnt}, 32'h0);
        check_eq("dr_state", 32'(dbg_state), 32'h1);

        // Saturation of both counters
        dbg_run_req = 1'b1;
        tick();
        dbg_run_req = 1'b0;
        check_eq("sat_run_state", 32'(dbg_state), 32'h0);
        bus.flush = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        check_eq("sat_bubble16", 32'(bubble_cnt), 32'd15);
        tick();
        tick();
        bus.flush = 1'b0;
        check_eq("sat_bubble18", 32'(bubble_cnt), 32'd15);
        check_eq("sat_valid", 32'(bus.out_valid), 32'h0);
        bus.stall = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        bus.stall = 1'b0;
        check_eq("sat_stall", 32'(stall_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the datapath (IF/ID, ID/EX, ...). Carries a data word, a PC value and a valid bit.
- Supports stall (hold), flush (bubble insertion) and a remembered flush that is applied when the stage next advances.
- Has an integrated debug run/halt/step-N controller and saturating stall/bubble performance counters.
- Sits between two pipeline stages. Debug inputs are driven by the debug unit; stall and flush are driven by the hazard unit.

Parameters:
- DATA_W, 32, width of the carried data/instruction word
- PC_W, 8, width of the carried PC value
- NOP_VALUE, 0, data value loaded on a bubble
- STEP_W, 8, width of the step-count request and the remaining-steps counter
- CNT_W, 16, width of each performance counter
- RESET_RUN, 1, FSM state after reset: 1 = RUN, 0 = HALT

Ports:
- clock  in  1  stage clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-high
- debug_reset  in  1  synchronous clear of pipeline contents and counters
- stall  in  1  hold current contents
- flush  in  1  replace the next captured word with a bubble
- in_data  in  DATA_W  upstream data
- in_pc  in  PC_W  upstream PC
- in_valid  in  1  upstream valid
- dbg_halt_req  in  1  one-cycle pulse: halt
- dbg_run_req  in  1  one-cycle pulse: free run
- dbg_step_req  in  1  one-cycle pulse: step dbg_step_count advances
- dbg_step_count  in  STEP_W  number of advances for a step request
- out_data  out  DATA_W  registered data
- out_pc  out  PC_W  registered PC
- out_valid  out  1  registered valid
- flush_pending  out  1  flush is latched, awaiting an advance
- dbg_state  out  2  00 RUN, 01 HALT, 10 STEP
- dbg_steps_left  out  STEP_W  remaining step advances
- stall_cnt  out  CNT_W  saturating count of stalled cycles
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (asynchronous):
  - out_data = NOP_VALUE, out_pc = 0, out_valid = 0.
  - flush_pending = 0, stall_cnt = 0, bubble_cnt = 0, dbg_steps_left = 0.
  - dbg_state = RUN if RESET_RUN = 1, else HALT.
- Priority on each falling edge: reset > debug_reset > advance logic.
- debug_reset: clears out_data, out_pc, out_valid, flush_pending and both counters to their reset values. FSM state and dbg_steps_left are unchanged, so a halted core stays halted.
- Definitions:
  - gate = (dbg_state == RUN) or (dbg_state == STEP).
  - advance = gate and not stall.
- On advance:
  - If flush or flush_pending: out_data = NOP_VALUE, out_valid = 0, out_pc = in_pc, flush_pending cleared, bubble_cnt incremented.
  - Otherwise: out_data = in_data, out_pc = in_pc, out_valid = in_valid.
- On no advance:
  - Outputs hold.
  - flush = 1 sets flush_pending. It is held until the next advance.
- stall_cnt increments on cycles where gate = 1 and stall = 1. Stalls while halted are not counted.
- Both counters saturate at all ones and never wrap.
- Latency: one falling edge from input to output when advancing.
- FSM in RUN:
  - dbg_halt_req goes to HALT.
  - dbg_step_req is ignored.
- FSM in HALT:
  - dbg_run_req goes to RUN.
  - dbg_step_req with dbg_step_count > 0 goes to STEP and loads dbg_steps_left = dbg_step_count.
  - dbg_step_req with dbg_step_count = 0 is ignored.
- FSM in STEP:
  - Each advance decrements dbg_steps_left.
  - An advance with dbg_steps_left = 1 goes to HALT, leaving dbg_steps_left = 0.
  - A stalled cycle does not consume a step.
  - dbg_halt_req goes to HALT and clears dbg_steps_left.
  - dbg_run_req goes to RUN and clears dbg_steps_left.
- Simultaneous debug requests: halt > run > step.
- Gating: the FSM transition takes effect after the edge. The edge that samples a request still uses the pre-transition state for the advance decision.

Decomposition:
- Shared package pipe_pkg holds:
  - the dbg_state encoding constants DBG_RUN, DBG_HALT, DBG_STEP
  - a 2-bit state typedef
  - the default NOP_VALUE constant shared with decode.
- One sub-module: dbg_step_ctrl, covering the FSM plus the steps-left counter. It outputs gate and a step_done pulse.
- Counters and data path stay in the top module.

Test Plan:
- Reset with RESET_RUN = 1, in_data = 0x12345678, in_pc = 0x04, in_valid = 1, no stall -> after 1 falling edge out_data = 0x12345678, out_pc = 0x04, out_valid = 1, dbg_state = RUN.
- stall = 1 for 3 cycles with flush = 1 in the 2nd of them, then stall = 0 with in_data = 0xAAAA0000, in_pc = 0x08 -> outputs hold during the stall, flush_pending = 1 after the 2nd cycle, then out_data = NOP_VALUE, out_valid = 0, out_pc = 0x08, flush_pending = 0, stall_cnt = 3, bubble_cnt = 1.
- dbg_halt_req, then 5 cycles of changing inputs -> outputs frozen, dbg_state = HALT, stall_cnt unchanged.
- In HALT, dbg_step_req with count = 3 and stall = 1 in one of the step cycles -> exactly 3 captures over 4 edges, dbg_steps_left 3→2→2→1→0, back to HALT.
- dbg_step_req with count = 0 -> no state change. Simultaneous halt and run requests in RUN -> HALT.
- debug_reset while halted with out_valid = 1 and bubble_cnt = 5 -> out_data = NOP_VALUE, out_pc = 0, out_valid = 0, counters = 0, dbg_state stays HALT.
- Force bubble_cnt to saturation (CNT_W = 4, 16 flushes) -> bubble_cnt = 15 and stays at 15.
